// File: rtl/ifft_twiddle_mult.sv
// rtl/ifft_twiddle_mult.sv - complex sample x twiddle multiplier, 3-stage pipeline
//
// Multiplies a signed complex sample by a twiddle factor fetched from an
// external synchronous-read ROM pair, then rounds half-up, saturates and
// presents the result. One global enable stalls the whole pipe on backpressure.
//
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready        input handshake; in_ready is the pipeline enable
//   in_re, in_im               signed complex sample (DW bits each)
//   in_k                       twiddle ROM index for this sample
//   rom_addr                   address to the twiddle ROMs (1-cycle read latency)
//   rom_re_data, rom_im_data   signed twiddle from the ROMs (Q FRAC)
//   out_valid / out_ready      output handshake
//   out_re, out_im             signed rounded and saturated product
//   sat_flag                   sticky saturation indicator
//   sat_clr                    synchronous clear of sat_flag (a new saturation wins)

module ifft_twiddle_mult #(
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_re,
    input  logic signed [DW-1:0] in_im,
    input  logic        [4:0]    in_k,
    output logic        [4:0]    rom_addr,
    input  logic signed [DW-1:0] rom_re_data,
    input  logic signed [DW-1:0] rom_im_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_re,
    output logic signed [DW-1:0] out_im,
    output logic                 sat_flag,
    input  logic                 sat_clr
);

    localparam int PW = 2 * DW;      // full-precision product width
    localparam int SW = 2 * DW + 1;  // sum width, one guard bit over a product

    localparam logic signed [SW-1:0] RND     = SW'(1) << (FRAC - 1);
    localparam logic signed [SW-1:0] SAT_MAX = {{(DW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(DW + 2){1'b1}}, {(DW - 1){1'b0}}};
    localparam logic signed [DW-1:0] OUT_MAX = {1'b0, {(DW - 1){1'b1}}};
    localparam logic signed [DW-1:0] OUT_MIN = {1'b1, {(DW - 1){1'b0}}};

    logic                 en;

    // S1: sample held while the ROM read for its index is in flight
    logic                 s1_valid;
    logic signed [DW-1:0] s1_re;
    logic signed [DW-1:0] s1_im;
    logic        [4:0]    s1_k;

    // S2: the four full-precision partial products
    logic                 s2_valid;
    logic signed [PW-1:0] s2_ac;
    logic signed [PW-1:0] s2_bd;
    logic signed [PW-1:0] s2_ad;
    logic signed [PW-1:0] s2_bc;

    // S3 input: sums, rounding and saturation
    logic signed [SW-1:0] sum_re;
    logic signed [SW-1:0] sum_im;
    logic signed [SW-1:0] sh_re;
    logic signed [SW-1:0] sh_im;
    logic                 sat_re;
    logic                 sat_im;
    logic signed [DW-1:0] res_re;
    logic signed [DW-1:0] res_im;

    // The output register is the only place a result can wait, so one
    // enable freezes every stage whenever it is occupied and not taken.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // While stalled, keep re-reading the index of the sample parked in S1 so
    // the ROM output still belongs to it when the pipe restarts.
    assign rom_addr = en ? in_k : s1_k;

    always_comb begin
        sum_re = SW'(s2_ac) - SW'(s2_bd);
        sum_im = SW'(s2_ad) + SW'(s2_bc);
        sh_re  = (sum_re + RND) >>> FRAC;
        sh_im  = (sum_im + RND) >>> FRAC;
        sat_re = (sh_re > SAT_MAX) || (sh_re < SAT_MIN);
        sat_im = (sh_im > SAT_MAX) || (sh_im < SAT_MIN);

        if (sh_re > SAT_MAX) begin
            res_re = OUT_MAX;
        end else if (sh_re < SAT_MIN) begin
            res_re = OUT_MIN;
        end else begin
            res_re = sh_re[DW-1:0];
        end

        if (sh_im > SAT_MAX) begin
            res_im = OUT_MAX;
        end else if (sh_im < SAT_MIN) begin
            res_im = OUT_MIN;
        end else begin
            res_im = sh_im[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_re     <= '0;
            s1_im     <= '0;
            s1_k      <= '0;
            s2_valid  <= 1'b0;
            s2_ac     <= '0;
            s2_bd     <= '0;
            s2_ad     <= '0;
            s2_bc     <= '0;
            out_valid <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (en) begin
                // in_ready equals en here, so in_valid alone marks acceptance;
                // a low in_valid becomes a bubble that rides down the pipe.
                s1_valid  <= in_valid;
                s1_re     <= in_re;
                s1_im     <= in_im;
                s1_k      <= in_k;

                s2_valid  <= s1_valid;
                s2_ac     <= PW'(s1_re) * PW'(rom_re_data);
                s2_bd     <= PW'(s1_im) * PW'(rom_im_data);
                s2_ad     <= PW'(s1_re) * PW'(rom_im_data);
                s2_bc     <= PW'(s1_im) * PW'(rom_re_data);

                out_valid <= s2_valid;
                out_re    <= res_re;
                out_im    <= res_im;
            end

            // Bubbles carry stale data and must not raise the flag.
            if (en && s2_valid && (sat_re || sat_im)) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end

endmodule
